// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encoding, Moore output decode and the
// default scan geometry also used by the LFSR/MISR blocks.
package bist_pkg;

    localparam int BIST_N_DEF = 13;
    localparam int BIST_M_DEF = 1023;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FINISH  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    typedef struct packed {
        logic mode;
        logic init;
        logic running;
        logic finish;
        logic bist_end;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF     = 5'b00000;
    localparam ctrl_t CTRL_INIT    = 5'b01000;
    localparam ctrl_t CTRL_SHIFT   = 5'b10100;
    localparam ctrl_t CTRL_CAPTURE = 5'b00100;
    localparam ctrl_t CTRL_FINISH  = 5'b00010;
    localparam ctrl_t CTRL_DONE    = 5'b00001;

    // Unused encodings decode to all-off so a corrupted state never drives scan.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        case (s)
            ST_INIT:    c = CTRL_INIT;
            ST_SHIFT:   c = CTRL_SHIFT;
            ST_CAPTURE: c = CTRL_CAPTURE;
            ST_FINISH:  c = CTRL_FINISH;
            ST_DONE:    c = CTRL_DONE;
            default:    c = CTRL_OFF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bist_seq_controller_if.sv
// Test-access side bundle of the BIST sequencer: start/abort/config in,
// Moore control outputs, verdict and progress counters out.
interface bist_seq_controller_if #(
    parameter int N_W = 8,
    parameter int M_W = 12,
    parameter int S_W = 1
) ();
    logic           bist_start;
    logic           abort;
    logic [N_W-1:0] cfg_n;
    logic [M_W-1:0] cfg_m;
    logic           sig_match;
    logic           mode;
    logic           init;
    logic           running;
    logic           finish;
    logic           bist_end;
    logic           pass;
    logic           aborted;
    logic [S_W-1:0] session;
    logic [N_W-1:0] shift_cnt;
    logic [M_W-1:0] pattern_cnt;

    modport master (
        output bist_start, abort, cfg_n, cfg_m, sig_match,
        input  mode, init, running, finish, bist_end, pass, aborted,
               session, shift_cnt, pattern_cnt
    );

    modport slave (
        input  bist_start, abort, cfg_n, cfg_m, sig_match,
        output mode, init, running, finish, bist_end, pass, aborted,
               session, shift_cnt, pattern_cnt
    );
endinterface

// File: rtl/bist_start_edge.sv
// Registered rising-edge detector for the level bist_start input; the edge is
// combinational off the current level, so a held-high start never retriggers.
module bist_start_edge (
    input  logic clock,
    input  logic bist_start,
    output logic start_edge
);
    logic prev_start;

    // Sampled unconditionally so a level held through reset is not seen as new.
    always_ff @(posedge clock) begin
        prev_start <= bist_start;
    end

    assign start_edge = bist_start & ~prev_start;
endmodule

// File: rtl/bist_seq_controller.sv
// Multi-session BIST sequencer: INIT, n_len SHIFT cycles + CAPTURE per pattern,
// FINISH per session, DONE with registered pass verdict; abort returns to IDLE.
module bist_seq_controller import bist_pkg::*; #(
    parameter int N_DEF        = BIST_N_DEF,
    parameter int M_DEF        = BIST_M_DEF,
    parameter int N_MAX        = 255,
    parameter int M_MAX        = 4095,
    parameter int NUM_SESSIONS = 2,
    parameter int N_W          = $clog2(N_MAX + 1),
    parameter int M_W          = $clog2(M_MAX + 1),
    parameter int S_W          = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1
) (
    input  logic clock,
    input  logic reset,
    bist_seq_controller_if.slave bus
);
    state_t         state, state_nxt;
    logic [N_W-1:0] shift_cnt, shift_cnt_nxt;
    logic [M_W-1:0] pattern_cnt, pattern_cnt_nxt;
    logic [S_W-1:0] session, session_nxt;
    logic [N_W-1:0] n_len, n_len_nxt;
    logic [M_W-1:0] m_len, m_len_nxt;
    logic           pass, pass_nxt;
    logic           aborted, aborted_nxt;
    logic           start_edge;
    logic [M_W-1:0] pattern_inc;
    ctrl_t          ctrl;

    bist_start_edge u_start_edge (
        .clock      (clock),
        .bist_start (bus.bist_start),
        .start_edge (start_edge)
    );

    assign pattern_inc = pattern_cnt + M_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            shift_cnt   <= '0;
            pattern_cnt <= '0;
            session     <= '0;
            n_len       <= '0;
            m_len       <= '0;
            pass        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_cnt   <= shift_cnt_nxt;
            pattern_cnt <= pattern_cnt_nxt;
            session     <= session_nxt;
            n_len       <= n_len_nxt;
            m_len       <= m_len_nxt;
            pass        <= pass_nxt;
            aborted     <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        shift_cnt_nxt   = shift_cnt;
        pattern_cnt_nxt = pattern_cnt;
        session_nxt     = session;
        n_len_nxt       = n_len;
        m_len_nxt       = m_len;
        pass_nxt        = pass;
        aborted_nxt     = aborted;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_edge && !bus.abort) begin
                    n_len_nxt       = (bus.cfg_n == '0) ? N_W'(N_DEF) :
                                      (bus.cfg_n > N_W'(N_MAX)) ? N_W'(N_MAX) : bus.cfg_n;
                    m_len_nxt       = (bus.cfg_m == '0) ? M_W'(M_DEF) :
                                      (bus.cfg_m > M_W'(M_MAX)) ? M_W'(M_MAX) : bus.cfg_m;
                    session_nxt     = '0;
                    pattern_cnt_nxt = '0;
                    shift_cnt_nxt   = '0;
                    aborted_nxt     = 1'b0;
                    pass_nxt        = 1'b1;
                    state_nxt       = ST_INIT;
                end
            end
            ST_INIT: state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (shift_cnt == n_len - N_W'(1)) begin
                    shift_cnt_nxt = '0;
                    state_nxt     = ST_CAPTURE;
                end else begin
                    shift_cnt_nxt = shift_cnt + N_W'(1);
                end
            end
            ST_CAPTURE: begin
                pattern_cnt_nxt = pattern_inc;
                state_nxt       = (pattern_inc == m_len) ? ST_FINISH : ST_SHIFT;
            end
            ST_FINISH: begin
                pass_nxt = pass & bus.sig_match;
                if (session == S_W'(NUM_SESSIONS - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    session_nxt     = session + S_W'(1);
                    pattern_cnt_nxt = '0;
                    state_nxt       = ST_INIT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort only bites while a run is active; IDLE/DONE fall through untouched.
        if (bus.abort && (state == ST_INIT || state == ST_SHIFT ||
                          state == ST_CAPTURE || state == ST_FINISH)) begin
            state_nxt       = ST_IDLE;
            aborted_nxt     = 1'b1;
            pass_nxt        = 1'b0;
            shift_cnt_nxt   = '0;
            pattern_cnt_nxt = '0;
            session_nxt     = '0;
        end
    end

    assign ctrl            = decode_ctrl(state);
    assign bus.mode        = ctrl.mode;
    assign bus.init        = ctrl.init;
    assign bus.running     = ctrl.running;
    assign bus.finish      = ctrl.finish;
    assign bus.bist_end    = ctrl.bist_end;
    assign bus.pass        = pass;
    assign bus.aborted     = aborted;
    assign bus.session     = session;
    assign bus.shift_cnt   = shift_cnt;
    assign bus.pattern_cnt = pattern_cnt;
endmodule

// File: tb/tb_bist_seq_controller.sv
// Directed bench: dut_a runs the small single-session geometry, dut_b the
// two-session default geometry with a widened cfg_n port for clamp testing.
module tb_bist_seq_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    bist_seq_controller_if #(.N_W(8), .M_W(12), .S_W(1)) ia ();
    bist_seq_controller_if #(.N_W(9), .M_W(12), .S_W(1)) ib ();

    bist_seq_controller #(
        .N_DEF(3), .M_DEF(2), .N_MAX(255), .M_MAX(4095), .NUM_SESSIONS(1),
        .N_W(8), .M_W(12), .S_W(1)
    ) dut_a (.clock(clock), .reset(reset), .bus(ia));

    bist_seq_controller #(
        .N_DEF(13), .M_DEF(1023), .N_MAX(255), .M_MAX(4095), .NUM_SESSIONS(2),
        .N_W(9), .M_W(12), .S_W(1)
    ) dut_b (.clock(clock), .reset(reset), .bus(ib));

    // Control vector order: {init, mode, running, finish, bist_end}
    function automatic logic [4:0] ctl_a();
        return {ia.init, ia.mode, ia.running, ia.finish, ia.bist_end};
    endfunction

    function automatic logic [4:0] ctl_b();
        return {ib.init, ib.mode, ib.running, ib.finish, ib.bist_end};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ia.bist_start = 0; ia.abort = 0; ia.cfg_n = '0; ia.cfg_m = '0; ia.sig_match = 0;
        ib.bist_start = 0; ib.abort = 0; ib.cfg_n = '0; ib.cfg_m = '0; ib.sig_match = 0;
        reset = 1;
        repeat (3) tick();
        checks++;
        if (ctl_a() !== 5'b00000) begin
            errors++; $display("FAIL reset_ctl_a got %b exp 00000", ctl_a());
        end
        checks++;
        if ({ib.pass, ib.aborted, ib.session, ib.shift_cnt, ib.pattern_cnt} !== '0) begin
            errors++; $display("FAIL reset_state_b got pass=%b ab=%b s=%0d sc=%0d pc=%0d exp all 0",
                               ib.pass, ib.aborted, ib.session, ib.shift_cnt, ib.pattern_cnt);
        end
        reset = 0;
        tick();
        checks++;
        if (ctl_b() !== 5'b00000) begin
            errors++; $display("FAIL idle_ctl_b got %b exp 00000", ctl_b());
        end
    endtask

    task automatic test_default_cfg();
        logic [4:0] exp_tab [11];
        exp_tab = '{5'b10000, 5'b01100, 5'b01100, 5'b01100, 5'b00100, 5'b01100,
                    5'b01100, 5'b01100, 5'b00100, 5'b00010, 5'b00001};
        ia.cfg_n = '0; ia.cfg_m = '0; ia.sig_match = 1; ia.bist_start = 1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) ia.bist_start = 0;
            checks++;
            if (ctl_a() !== exp_tab[c-1]) begin
                errors++; $display("FAIL default_seq c%0d got %b exp %b", c, ctl_a(), exp_tab[c-1]);
            end
            if (c == 3) begin
                checks++;
                if (ia.shift_cnt !== 8'd1) begin
                    errors++; $display("FAIL default_shift_cnt got %0d exp 1", ia.shift_cnt);
                end
            end
        end
        checks++;
        if (ia.pass !== 1'b1 || ia.pattern_cnt !== 12'd2) begin
            errors++; $display("FAIL default_done got pass=%b pc=%0d exp pass=1 pc=2", ia.pass, ia.pattern_cnt);
        end
    endtask

    task automatic test_sessions();
        int inits = 0;
        ib.cfg_n = 9'd5; ib.cfg_m = 12'd1; ib.sig_match = 1; ib.bist_start = 1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 1) ib.bist_start = 0;
            if (ib.init) inits++;
            if (c == 8 || c == 16) begin
                checks++;
                if (ctl_b() !== 5'b00010 || ib.session !== 1'((c == 16) ? 1 : 0)) begin
                    errors++; $display("FAIL sess_finish c%0d got ctl=%b s=%0d exp ctl=00010 s=%0d",
                                       c, ctl_b(), ib.session, (c == 16) ? 1 : 0);
                end
            end
            if (c == 9) begin
                checks++;
                if (ctl_b() !== 5'b10000 || ib.session !== 1'b1) begin
                    errors++; $display("FAIL sess_init1 got ctl=%b s=%0d exp ctl=10000 s=1", ctl_b(), ib.session);
                end
                ib.sig_match = 0;
            end
        end
        checks++;
        if (ctl_b() !== 5'b00001 || ib.pass !== 1'b0) begin
            errors++; $display("FAIL sess_done got ctl=%b pass=%b exp ctl=00001 pass=0", ctl_b(), ib.pass);
        end
        checks++;
        if (inits !== 2) begin
            errors++; $display("FAIL sess_init_pulses got %0d exp 2", inits);
        end
    endtask

    task automatic test_abort();
        ib.cfg_n = 9'd4; ib.cfg_m = 12'd3; ib.sig_match = 1; ib.bist_start = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) ib.bist_start = 0;
        end
        checks++;
        if (ctl_b() !== 5'b01100 || ib.shift_cnt !== 9'd1 || ib.pattern_cnt !== 12'd1) begin
            errors++; $display("FAIL abort_pre got ctl=%b sc=%0d pc=%0d exp ctl=01100 sc=1 pc=1",
                               ctl_b(), ib.shift_cnt, ib.pattern_cnt);
        end
        ib.abort = 1;
        tick();
        ib.abort = 0;
        checks++;
        if (ctl_b() !== 5'b00000 || ib.aborted !== 1'b1 || ib.pass !== 1'b0) begin
            errors++; $display("FAIL abort_out got ctl=%b ab=%b pass=%b exp ctl=00000 ab=1 pass=0",
                               ctl_b(), ib.aborted, ib.pass);
        end
        checks++;
        if (ib.shift_cnt !== 9'd0 || ib.pattern_cnt !== 12'd0) begin
            errors++; $display("FAIL abort_counters got sc=%0d pc=%0d exp 0 0", ib.shift_cnt, ib.pattern_cnt);
        end
        ib.cfg_n = 9'd2; ib.cfg_m = 12'd2; ib.bist_start = 1;
        tick();
        ib.bist_start = 0;
        checks++;
        if (ctl_b() !== 5'b10000 || ib.aborted !== 1'b0 || ib.pass !== 1'b1) begin
            errors++; $display("FAIL abort_restart got ctl=%b ab=%b pass=%b exp ctl=10000 ab=0 pass=1",
                               ctl_b(), ib.aborted, ib.pass);
        end
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (c == 16) begin
                checks++;
                if (ctl_b() !== 5'b00010) begin
                    errors++; $display("FAIL rerun_finish got %b exp 00010", ctl_b());
                end
            end
        end
        checks++;
        if (ctl_b() !== 5'b00001 || ib.pass !== 1'b1) begin
            errors++; $display("FAIL rerun_done got ctl=%b pass=%b exp ctl=00001 pass=1", ctl_b(), ib.pass);
        end
        ib.abort = 1;
        tick();
        ib.abort = 0;
        checks++;
        if (ctl_b() !== 5'b00001 || ib.aborted !== 1'b0 || ib.pass !== 1'b1) begin
            errors++; $display("FAIL abort_in_done got ctl=%b ab=%b pass=%b exp ctl=00001 ab=0 pass=1",
                               ctl_b(), ib.aborted, ib.pass);
        end
    endtask

    task automatic test_held_start();
        ib.cfg_n = 9'd1; ib.cfg_m = 12'd1; ib.bist_start = 1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 9 || c == 14) begin
                checks++;
                if (ctl_b() !== 5'b00001) begin
                    errors++; $display("FAIL held_done c%0d got %b exp 00001", c, ctl_b());
                end
            end
        end
        ib.bist_start = 0;
        tick();
        ib.cfg_n = 9'd3; ib.cfg_m = 12'd2; ib.bist_start = 1;
        tick();
        checks++;
        if (ctl_b() !== 5'b10000 || ib.session !== 1'b0) begin
            errors++; $display("FAIL held_restart got ctl=%b s=%0d exp ctl=10000 s=0", ctl_b(), ib.session);
        end
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c == 4) begin
                checks++;
                if (ctl_b() !== 5'b01100 || ib.shift_cnt !== 9'd2) begin
                    errors++; $display("FAIL held_newcfg_shift got ctl=%b sc=%0d exp ctl=01100 sc=2", ctl_b(), ib.shift_cnt);
                end
            end
            if (c == 5) begin
                checks++;
                if (ctl_b() !== 5'b00100) begin
                    errors++; $display("FAIL held_newcfg_capture got %b exp 00100", ctl_b());
                end
            end
        end
        checks++;
        if (ctl_b() !== 5'b00100 || ib.pattern_cnt !== 12'd1) begin
            errors++; $display("FAIL held_second_capture got ctl=%b pc=%0d exp ctl=00100 pc=1", ctl_b(), ib.pattern_cnt);
        end
    endtask

    task automatic test_reset_mid_capture();
        reset = 1;
        tick();
        checks++;
        if (ctl_b() !== 5'b00000 || ib.pattern_cnt !== 12'd0 || ib.shift_cnt !== 9'd0 ||
            ib.session !== 1'b0 || ib.aborted !== 1'b0 || ib.pass !== 1'b0) begin
            errors++; $display("FAIL reset_mid got ctl=%b pc=%0d sc=%0d s=%0d ab=%b pass=%b exp all 0",
                               ctl_b(), ib.pattern_cnt, ib.shift_cnt, ib.session, ib.aborted, ib.pass);
        end
        reset = 0;
        ib.bist_start = 0;
        tick();
        checks++;
        if (ctl_b() !== 5'b00000) begin
            errors++; $display("FAIL reset_mid_idle got %b exp 00000", ctl_b());
        end
    endtask

    task automatic test_clamp();
        int mode_cycles = 0;
        ib.cfg_n = 9'd300; ib.cfg_m = 12'd1; ib.sig_match = 1; ib.bist_start = 1;
        for (int c = 1; c <= 257; c++) begin
            tick();
            if (c == 1) ib.bist_start = 0;
            if (ib.mode) mode_cycles++;
            if (c == 256) begin
                checks++;
                if (ib.shift_cnt !== 9'd254) begin
                    errors++; $display("FAIL clamp_last_shift got %0d exp 254", ib.shift_cnt);
                end
            end
        end
        checks++;
        if (mode_cycles !== 255 || ctl_b() !== 5'b00100) begin
            errors++; $display("FAIL clamp_len got mode_cycles=%0d ctl=%b exp 255 ctl=00100", mode_cycles, ctl_b());
        end
        ib.abort = 1;
        tick();
        ib.abort = 0;
        checks++;
        if (ctl_b() !== 5'b00000 || ib.aborted !== 1'b1) begin
            errors++; $display("FAIL clamp_abort got ctl=%b ab=%b exp ctl=00000 ab=1", ctl_b(), ib.aborted);
        end
    endtask

    task automatic test_cfg_change();
        ib.cfg_n = 9'd1; ib.cfg_m = 12'd3; ib.bist_start = 1;
        tick();
        ib.bist_start = 0; ib.cfg_m = 12'd1; ib.cfg_n = 9'd7;
        checks++;
        if (ctl_b() !== 5'b10000 || ib.aborted !== 1'b0) begin
            errors++; $display("FAIL cfgchg_init got ctl=%b ab=%b exp ctl=10000 ab=0", ctl_b(), ib.aborted);
        end
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (c == 4) begin
                checks++;
                if (ctl_b() !== 5'b01100 || ib.pattern_cnt !== 12'd1) begin
                    errors++; $display("FAIL cfgchg_mid got ctl=%b pc=%0d exp ctl=01100 pc=1", ctl_b(), ib.pattern_cnt);
                end
            end
        end
        checks++;
        if (ctl_b() !== 5'b00010 || ib.pattern_cnt !== 12'd3) begin
            errors++; $display("FAIL cfgchg_finish got ctl=%b pc=%0d exp ctl=00010 pc=3", ctl_b(), ib.pattern_cnt);
        end
    endtask

    task automatic test_abort_with_start();
        ib.abort = 1;
        tick();
        ib.bist_start = 1;
        tick();
        checks++;
        if (ctl_b() !== 5'b00000 || ib.aborted !== 1'b1) begin
            errors++; $display("FAIL abort_blocks_start got ctl=%b ab=%b exp ctl=00000 ab=1", ctl_b(), ib.aborted);
        end
        ib.abort = 0;
        tick();
        checks++;
        if (ctl_b() !== 5'b00000) begin
            errors++; $display("FAIL held_after_abort got %b exp 00000", ctl_b());
        end
        ib.bist_start = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_default_cfg();
        test_sessions();
        test_abort();
        test_held_start();
        test_reset_mid_capture();
        test_clamp();
        test_cfg_change();
        test_abort_with_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
